// File: rtl/mux_sel_arbiter.sv
// Round-robin owner arbiter for the 8:1 mux select, with hold limit and idle gap.
// Optional MUX_ARB_LOCK_EN adds a lock input that lets the owner extend its grant.
module mux_sel_arbiter #(
  parameter int unsigned HOLD_MAX   = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic [3:0] hold_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] gap_cnt_q, gap_cnt_d;

  logic       found;
  logic [2:0] win;
  logic [2:0] idx;
  logic       release_now;
  logic [3:0] hold_next;
  state_t     after_rel;

  // Search for the first requester after the last owner, wrapping 7 to 0.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Release condition and hold counter increment for the current owner.
  always_comb begin
`ifdef MUX_ARB_LOCK_EN
    release_now = !req[sel_q] ||
                  (!lock && (hold_cnt_q >= 4'(HOLD_MAX)));
    hold_next   = (hold_cnt_q == 4'd15) ? 4'd15 : hold_cnt_q + 4'd1;
`else
    release_now = !req[sel_q] || (hold_cnt_q == 4'(HOLD_MAX));
    hold_next   = hold_cnt_q + 4'd1;
`endif
    after_rel = (GAP_CYCLES > 0) ? GAP : IDLE;
  end

  // Next-state and next-output logic of the arbiter FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          sel_d      = win;
          gnt_d      = 8'd1 << win;
          hold_cnt_d = 4'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d    = after_rel;
          gnt_d      = 8'd0;
          hold_cnt_d = 4'd0;
          ptr_d      = sel_q;
          gap_cnt_d  = 2'd0;
        end else begin
          hold_cnt_d = hold_next;
        end
      end
      GAP: begin
        if (gap_cnt_q == 2'(GAP_CYCLES - 1)) begin
          state_d   = IDLE;
          gap_cnt_d = 2'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = 8'd0;
        hold_cnt_d = 4'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd7;
      sel_q      <= 3'd0;
      gnt_q      <= 8'd0;
      busy_q     <= 1'b0;
      hold_cnt_q <= 4'd0;
      gap_cnt_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign sel      = sel_q;
  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with HOLD_MAX=4, GAP_CYCLES=1.
// Lock scenario runs only when MUX_ARB_LOCK_EN is defined.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic [3:0] hold_cnt;

  int n_assert;
  int n_fail;

  mux_sel_arbiter #(
    .HOLD_MAX  (4),
    .GAP_CYCLES(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
`ifdef MUX_ARB_LOCK_EN
    .lock    (lock),
`endif
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] eg,
                            input logic [2:0] es, input logic eb,
                            input logic [3:0] eh);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".sel"}, {5'd0, sel}, {5'd0, es});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
    chk({tag, ".hold"}, {4'd0, hold_cnt}, {4'd0, eh});
  endtask

  initial begin
    logic [7:0] g;
    logic [2:0] s;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    req = 8'h00;
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b0;
`endif

    // Reset with all requests asserted
    req = 8'hFF;
    tick();
    expect_out("rst0", 8'h00, 3'd0, 1'b0, 4'd0);
    tick();
    expect_out("rst1", 8'h00, 3'd0, 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    expect_out("first", 8'h01, 3'd0, 1'b1, 4'd1);

    // Fairness: order 0..7 then 0, four cycles each, two low cycles
    for (int k = 0; k <= 8; k++) begin
      s = 3'(k % 8);
      g = 8'd1 << s;
      for (int c = 1; c <= 4; c++) begin
        expect_out($sformatf("rr%0d_c%0d", k, c), g, s, 1'b1, 4'(c));
        tick();
      end
      expect_out($sformatf("rr%0d_gap", k), 8'h00, s, 1'b1, 4'd0);
      tick();
      expect_out($sformatf("rr%0d_idle", k), 8'h00, s, 1'b0, 4'd0);
      tick();
    end

    // Hold limit with a single requester
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 8'h04;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 4; c++) begin
        expect_out($sformatf("hl%0d_c%0d", r, c), 8'h04, 3'd2, 1'b1, 4'(c));
        tick();
      end
      expect_out($sformatf("hl%0d_gap", r), 8'h00, 3'd2, 1'b1, 4'd0);
      tick();
      expect_out($sformatf("hl%0d_idle", r), 8'h00, 3'd2, 1'b0, 4'd0);
      tick();
    end

    // Early release of owner 6, wrap to 0, then back to 6
    rst = 1'b0;
    req = 8'h00;
    tick();
    rst = 1'b1;
    req = 8'h40;
    tick();
    expect_out("er_g6a", 8'h40, 3'd6, 1'b1, 4'd1);
    req = 8'h41;
    tick();
    expect_out("er_g6b", 8'h40, 3'd6, 1'b1, 4'd2);
    req = 8'h01;
    tick();
    expect_out("er_rel", 8'h00, 3'd6, 1'b1, 4'd0);
    tick();
    expect_out("er_idle", 8'h00, 3'd6, 1'b0, 4'd0);
    req = 8'h41;
    tick();
    expect_out("er_wrap0", 8'h01, 3'd0, 1'b1, 4'd1);
    req = 8'h40;
    tick();
    expect_out("er_rel0", 8'h00, 3'd0, 1'b1, 4'd0);
    tick();
    expect_out("er_idle0", 8'h00, 3'd0, 1'b0, 4'd0);
    tick();
    expect_out("er_g6c", 8'h40, 3'd6, 1'b1, 4'd1);

    // Mid-grant reset restores the pointer to 7
    rst = 1'b0;
    req = 8'h00;
    tick();
    rst = 1'b1;
    req = 8'h04;
    tick();
    expect_out("mr_g2", 8'h04, 3'd2, 1'b1, 4'd1);
    req = 8'h00;
    tick();
    tick();
    expect_out("mr_idle", 8'h00, 3'd2, 1'b0, 4'd0);
    req = 8'h08;
    tick();
    expect_out("mr_g3a", 8'h08, 3'd3, 1'b1, 4'd1);
    tick();
    expect_out("mr_g3b", 8'h08, 3'd3, 1'b1, 4'd2);
    rst = 1'b0;
    tick();
    expect_out("mr_rst", 8'h00, 3'd0, 1'b0, 4'd0);
    rst = 1'b1;
    req = 8'h0A;
    tick();
    expect_out("mr_after", 8'h02, 3'd1, 1'b1, 4'd1);

`ifdef MUX_ARB_LOCK_EN
    // Lock extends owner 0 past the hold limit
    rst = 1'b0;
    req = 8'h00;
    tick();
    rst = 1'b1;
    req = 8'h03;
    lock = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      expect_out($sformatf("lk_c%0d", c), 8'h01, 3'd0, 1'b1, 4'(c));
      if (c < 10) tick();
    end
    lock = 1'b0;
    tick();
    expect_out("lk_rel", 8'h00, 3'd0, 1'b1, 4'd0);
    tick();
    expect_out("lk_idle", 8'h00, 3'd0, 1'b0, 4'd0);
    tick();
    expect_out("lk_next", 8'h02, 3'd1, 1'b1, 4'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
